// File: rtl/wb_regfile.sv
// Write-back select plus 32-entry integer register file with write-first bypass to ID.
// Commit lands one edge after WB presents it; no backpressure, every cycle is accepted.
module wb_regfile #(
   parameter int XLEN  = 32,
   parameter int NREG  = 32,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       WB_wb,
   input  logic [XLEN-1:0]  MemDout_wb,
   input  logic [XLEN-1:0]  ALUResult_wb,
   input  logic [4:0]       rdAddr_wb,
   input  logic [4:0]       rs1Addr_id,
   input  logic [4:0]       rs2Addr_id,
   output logic [XLEN-1:0]  rs1Data_id,
   output logic [XLEN-1:0]  rs2Data_id,
   output logic [XLEN-1:0]  WBData_wb,
   output logic [CNT_W-1:0] wb_count
);

   logic [XLEN-1:0]  regs_q [NREG];
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             reg_write;
   logic             commit;

   assign reg_write = WB_wb[1];
   assign WBData_wb = WB_wb[0] ? MemDout_wb : ALUResult_wb;
   assign commit    = reg_write && (rdAddr_wb != 5'd0);
   assign cnt_d     = cnt_q + CNT_W'(1);
   assign wb_count  = cnt_q;

   // x0 is never written, so it stays at its reset value of zero
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
         cnt_q <= '0;
      end else if (commit) begin
         regs_q[rdAddr_wb] <= WBData_wb;
         cnt_q             <= cnt_d;
      end
   end

   // Bypass ignores rst: only stored state is cleared by reset
   always_comb begin
      rs1Data_id = regs_q[rs1Addr_id];
      if (rs1Addr_id == 5'd0) begin
         rs1Data_id = '0;
      end else if (reg_write && (rdAddr_wb == rs1Addr_id)) begin
         rs1Data_id = WBData_wb;
      end
   end

   always_comb begin
      rs2Data_id = regs_q[rs2Addr_id];
      if (rs2Addr_id == 5'd0) begin
         rs2Data_id = '0;
      end else if (reg_write && (rdAddr_wb == rs2Addr_id)) begin
         rs2Data_id = WBData_wb;
      end
   end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed scoreboard bench for wb_regfile; counter width reduced to 4 to reach wrap.
module tb_wb_regfile;

   logic        clk;
   logic        rst;
   logic [1:0]  WB_wb;
   logic [31:0] MemDout_wb;
   logic [31:0] ALUResult_wb;
   logic [4:0]  rdAddr_wb;
   logic [4:0]  rs1Addr_id;
   logic [4:0]  rs2Addr_id;
   logic [31:0] rs1Data_id;
   logic [31:0] rs2Data_id;
   logic [31:0] WBData_wb;
   logic [3:0]  wb_count;

   wb_regfile #(.XLEN(32), .NREG(32), .CNT_W(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .WB_wb        (WB_wb),
      .MemDout_wb   (MemDout_wb),
      .ALUResult_wb (ALUResult_wb),
      .rdAddr_wb    (rdAddr_wb),
      .rs1Addr_id   (rs1Addr_id),
      .rs2Addr_id   (rs2Addr_id),
      .rs1Data_id   (rs1Data_id),
      .rs2Data_id   (rs2Data_id),
      .WBData_wb    (WBData_wb),
      .wb_count     (wb_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam int K_RS1 = 0;
   localparam int K_RS2 = 1;
   localparam int K_WBD = 2;
   localparam int K_CNT = 3;

   typedef struct {
      int          kind;
      int          tag;
      logic [31:0] exp;
   } exp_t;

   exp_t q[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   task automatic expect_val(input int kind, input int tag, input logic [31:0] exp);
      exp_t e;
      e.kind = kind;
      e.tag  = tag;
      e.exp  = exp;
      q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      WB_wb        = 2'b00;
      MemDout_wb   = 32'h0;
      ALUResult_wb = 32'h0;
      rdAddr_wb    = 5'd0;
   endtask

   // Monitor: outputs are combinational, so everything queued for this cycle is
   // compared mid-cycle, away from the edge that consumes the inputs.
   always @(negedge clk) begin
      while (q.size() > 0) begin
         exp_t        e;
         logic [31:0] act;
         string       nm;
         e = q.pop_front();
         case (e.kind)
            K_RS1:   begin act = rs1Data_id;              nm = "rs1Data";  end
            K_RS2:   begin act = rs2Data_id;              nm = "rs2Data";  end
            K_WBD:   begin act = WBData_wb;               nm = "WBData";   end
            default: begin act = {28'h0, wb_count};       nm = "wb_count"; end
         endcase
         n_chk++;
         if (act !== e.exp) begin
            n_fail++;
            $display("FAIL %s tag=%0d actual=%08h required=%08h", nm, e.tag, act, e.exp);
         end
      end
   end

   initial begin
      rst        = 1'b1;
      rs1Addr_id = 5'd0;
      rs2Addr_id = 5'd0;
      idle();
      tick();
      tick();

      // 1: reset state on every index, both ports
      rst = 1'b0;
      expect_val(K_CNT, 100, 32'h0);
      for (int a = 0; a < 32; a++) begin
         rs1Addr_id = 5'(a);
         rs2Addr_id = 5'(31 - a);
         expect_val(K_RS1, 100 + a, 32'h0);
         expect_val(K_RS2, 100 + a, 32'h0);
         tick();
      end

      // 2: ALU write to x5
      WB_wb = 2'b10; ALUResult_wb = 32'hDEADBEEF; MemDout_wb = 32'h0BAD_F00D; rdAddr_wb = 5'd5;
      rs1Addr_id = 5'd1; rs2Addr_id = 5'd5;
      expect_val(K_WBD, 200, 32'hDEADBEEF);
      expect_val(K_RS1, 200, 32'h0);
      expect_val(K_RS2, 200, 32'hDEADBEEF);
      tick();
      idle(); rs1Addr_id = 5'd5;
      expect_val(K_RS1, 201, 32'hDEADBEEF);
      expect_val(K_CNT, 201, 32'd1);
      tick();

      // 3: load write to x7 with same-cycle bypass
      WB_wb = 2'b11; MemDout_wb = 32'h1234_5678; ALUResult_wb = 32'h0000_0055; rdAddr_wb = 5'd7;
      rs1Addr_id = 5'd5; rs2Addr_id = 5'd7;
      expect_val(K_RS2, 300, 32'h1234_5678);
      expect_val(K_RS1, 300, 32'hDEADBEEF);
      expect_val(K_WBD, 300, 32'h1234_5678);
      expect_val(K_CNT, 300, 32'd1);
      tick();
      idle();
      expect_val(K_RS2, 301, 32'h1234_5678);
      expect_val(K_CNT, 301, 32'd2);
      tick();

      // 4: x0 guard
      WB_wb = 2'b10; ALUResult_wb = 32'hFFFF_FFFF; rdAddr_wb = 5'd0;
      rs1Addr_id = 5'd0; rs2Addr_id = 5'd0;
      expect_val(K_RS1, 400, 32'h0);
      expect_val(K_RS2, 400, 32'h0);
      expect_val(K_WBD, 400, 32'hFFFF_FFFF);
      tick();
      idle();
      expect_val(K_RS1, 401, 32'h0);
      expect_val(K_CNT, 401, 32'd2);
      tick();

      // 5: RegWrite=0 leaves x3 alone but still drives WBData
      WB_wb = 2'b10; ALUResult_wb = 32'h0000_0033; rdAddr_wb = 5'd3;
      tick();
      WB_wb = 2'b01; MemDout_wb = 32'hAAAA_AAAA; ALUResult_wb = 32'h0000_0077; rdAddr_wb = 5'd3;
      rs1Addr_id = 5'd3; rs2Addr_id = 5'd3;
      expect_val(K_RS1, 500, 32'h0000_0033);
      expect_val(K_RS2, 500, 32'h0000_0033);
      expect_val(K_WBD, 500, 32'hAAAA_AAAA);
      expect_val(K_CNT, 500, 32'd3);
      tick();
      idle();
      expect_val(K_RS1, 501, 32'h0000_0033);
      expect_val(K_CNT, 501, 32'd3);
      tick();

      // 6a: reset wins over a commit; bypass still visible while rst is high
      rst = 1'b1;
      WB_wb = 2'b10; ALUResult_wb = 32'h0000_0099; rdAddr_wb = 5'd9;
      rs1Addr_id = 5'd9; rs2Addr_id = 5'd3;
      expect_val(K_RS1, 600, 32'h0000_0099);
      expect_val(K_RS2, 600, 32'h0000_0033);
      tick();
      rst = 1'b0; idle();
      expect_val(K_RS1, 601, 32'h0);
      expect_val(K_RS2, 601, 32'h0);
      expect_val(K_CNT, 601, 32'd0);
      tick();

      // 6b: 16 commits wrap the 4-bit counter back to zero
      for (int i = 0; i < 16; i++) begin
         WB_wb = 2'b10; ALUResult_wb = 32'(i + 1); rdAddr_wb = 5'((i % 15) + 1);
         expect_val(K_CNT, 700 + i, 32'(i));
         tick();
      end
      idle();
      rs1Addr_id = 5'd1; rs2Addr_id = 5'd2;
      expect_val(K_CNT, 716, 32'd0);
      expect_val(K_RS1, 716, 32'd16);
      expect_val(K_RS2, 716, 32'd2);
      tick();
      rs1Addr_id = 5'd15; rs2Addr_id = 5'd15;
      expect_val(K_RS1, 717, 32'd15);
      expect_val(K_RS2, 717, 32'd15);
      tick();

      @(negedge clk);
      #1;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
